// File: rtl/div_share_arb.sv
// Round-robin arbiter sharing one combinational 16-bit divider among NREQ requesters.
// Optional build macro DIV_ZERO_BYPASS_EN: zero divisors skip EXEC and answer with 16'hFFFF.
module div (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] out,
  output logic        ov
);
  always_comb begin
    out = (b == 16'd0) ? 16'd0 : a / b;
    ov  = (out == 16'd0);
  end
endmodule

module div_share_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*16-1:0] dividend,
  input  logic [NREQ*16-1:0] divisor,
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [15:0]       quotient,
  output logic              ov,
  output logic              dz
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  rr_q, rr_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [15:0]     a_q, a_d, b_q, b_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [15:0]     quot_q, quot_d;
  logic            ov_q, ov_d, dz_q, dz_d;

  logic            win_valid;
  logic [IDW-1:0]  win_idx, rr_next;
  logic [15:0]     win_a, win_b;
  logic [15:0]     div_out;
  logic            div_ov;

  div u_div (.a(a_q), .b(b_q), .out(div_out), .ov(div_ov));

  // First requester at or above the rr pointer, wrapping modulo NREQ.
  always_comb begin
    int idx;
    idx       = 0;
    win_valid = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!win_valid && req[idx]) begin
        win_valid = 1'b1;
        win_idx   = IDW'(idx);
      end
    end
  end

  assign win_a   = dividend[16*win_idx +: 16];
  assign win_b   = divisor[16*win_idx +: 16];
  assign rr_next = (win_idx == IDW'(NREQ-1)) ? '0 : win_idx + IDW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      id_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      gnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      quot_q      <= '0;
      ov_q        <= 1'b0;
      dz_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      id_q        <= id_d;
      a_q         <= a_d;
      b_q         <= b_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      quot_q      <= quot_d;
      ov_q        <= ov_d;
      dz_q        <= dz_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    id_d        = id_q;
    a_d         = a_q;
    b_d         = b_q;
    gnt_d       = '0;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    quot_d      = quot_q;
    ov_d        = ov_q;
    dz_d        = dz_q;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          a_d     = win_a;
          b_d     = win_b;
          id_d    = win_idx;
          gnt_d   = NREQ'(1) << win_idx;
          rr_d    = rr_next;
          state_d = EXEC;
`ifdef DIV_ZERO_BYPASS_EN
          if (win_b == 16'd0) begin
            quot_d      = 16'hFFFF;
            ov_d        = 1'b1;
            dz_d        = 1'b1;
            rsp_id_d    = win_idx;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
          end
`endif
        end
      end
      EXEC: begin
        quot_d      = div_out;
        ov_d        = div_ov;
        dz_d        = (b_q == 16'd0);
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
  end

  assign gnt       = gnt_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign quotient  = quot_q;
  assign ov        = ov_q;
  assign dz        = dz_q;
endmodule

// File: tb/tb_div_share_arb.sv
// Directed table-driven bench for div_share_arb plus hand sequences for
// round-robin cadence, backpressure and reset during EXEC.
module tb_div_share_arb;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [63:0] dividend, divisor;
  logic [3:0]  gnt;
  logic        busy, rsp_valid, rsp_ready;
  logic [1:0]  rsp_id;
  logic [15:0] quotient;
  logic        ov, dz;

  int n_vec = 0;
  int n_err = 0;

  div_share_arb #(.NREQ(4), .IDW(2)) dut (
    .clk(clk), .rst(rst), .req(req), .dividend(dividend), .divisor(divisor),
    .gnt(gnt), .busy(busy), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .quotient(quotient), .ov(ov), .dz(dz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [63:0] dvd;
    logic [63:0] dvs;
    logic [3:0]  gnt;
    logic [1:0]  id;
    logic [15:0] q;
    logic        ov;
    logic        dz;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input vec_t v);
    logic byp;
    byp = 1'b0;
`ifdef DIV_ZERO_BYPASS_EN
    byp = v.dz;
`endif
    req = v.req; dividend = v.dvd; divisor = v.dvs; rsp_ready = 1'b1;
    step();
    chk("gnt", 32'(gnt), 32'(v.gnt));
    chk("busy_op", 32'(busy), 32'd1);
    req = 4'b0000;
    if (!byp) begin
      chk("valid_early", 32'(rsp_valid), 32'd0);
      step();
      chk("gnt_pulse", 32'(gnt), 32'd0);
    end
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_id", 32'(rsp_id), 32'(v.id));
    chk("quotient", 32'(quotient), 32'(v.q));
    chk("ov", 32'(ov), 32'(v.ov));
    chk("dz", 32'(dz), 32'(v.dz));
    $display("op req=%b gnt=%b id=%0d q=%0d ov=%0d dz=%0d", v.req, gnt, rsp_id, quotient, ov, dz);
    step();
    chk("valid_clr", 32'(rsp_valid), 32'd0);
    chk("idle", 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  logic [15:0] zq;
  logic [3:0]  exp_g;
  logic [15:0] rr_q_exp [4];

  initial begin
    req = '0; dividend = '0; divisor = '0; rsp_ready = 1'b1;
`ifdef DIV_ZERO_BYPASS_EN
    zq = 16'hFFFF;
`else
    zq = 16'd0;
`endif
    tbl[0] = '{4'b0001, {48'd0, 16'd100},             {48'd0, 16'd7},            4'b0001, 2'd0, 16'd14,    1'b0, 1'b0};
    tbl[1] = '{4'b0100, {16'd0, 16'd65535, 32'd0},    {16'd0, 16'd1, 32'd0},     4'b0100, 2'd2, 16'd65535, 1'b0, 1'b0};
    tbl[2] = '{4'b0100, {16'd0, 16'd5, 32'd0},        {16'd0, 16'd9, 32'd0},     4'b0100, 2'd2, 16'd0,     1'b1, 1'b0};
    tbl[3] = '{4'b0010, {32'd0, 16'd1000, 16'd0},     {32'd0, 16'd0, 16'd0},     4'b0010, 2'd1, zq,        1'b1, 1'b1};
    tbl[4] = '{4'b1010, {16'd81, 16'd0, 16'd7, 16'd0}, {16'd9, 16'd0, 16'd2, 16'd0}, 4'b1000, 2'd3, 16'd9, 1'b0, 1'b0};
    tbl[5] = '{4'b1010, {16'd81, 16'd0, 16'd7, 16'd0}, {16'd9, 16'd0, 16'd2, 16'd0}, 4'b0010, 2'd1, 16'd3, 1'b0, 1'b0};
    tbl[6] = '{4'b0001, {48'd0, 16'd0},               {48'd0, 16'd5},            4'b0001, 2'd0, 16'd0,     1'b1, 1'b0};

    do_reset();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_q", 32'(quotient), 32'd0);
    chk("rst_id", 32'(rsp_id), 32'd0);
    chk("rst_ovdz", 32'({ov, dz}), 32'd0);

    for (int i = 0; i < 7; i++) run_op(tbl[i]);

    // Continuous 4-way contention from a fresh rr pointer
    do_reset();
    rr_q_exp[0] = 16'd3; rr_q_exp[1] = 16'd6; rr_q_exp[2] = 16'd10; rr_q_exp[3] = 16'd13;
    req = 4'b1111; rsp_ready = 1'b1;
    dividend = {16'd40, 16'd30, 16'd20, 16'd10};
    divisor  = {16'd3, 16'd3, 16'd3, 16'd3};
    for (int c = 0; c < 15; c++) begin
      step();
      exp_g = (c % 3 == 0) ? (4'b0001 << ((c / 3) % 4)) : 4'b0000;
      chk("rr_gnt", 32'(gnt), 32'(exp_g));
      chk("rr_valid", 32'(rsp_valid), 32'(c % 3 == 1));
      if (c % 3 == 1) begin
        chk("rr_q", 32'(quotient), 32'(rr_q_exp[(c / 3) % 4]));
        chk("rr_id", 32'(rsp_id), 32'((c / 3) % 4));
        $display("rr cycle=%0d id=%0d q=%0d", c, rsp_id, quotient);
      end
    end
    req = 4'b0000;
    step();

    // Backpressure with a competing request waiting in RESP
    req = 4'b0001; rsp_ready = 1'b0;
    dividend = {32'd0, 16'd9, 16'd50};
    divisor  = {32'd0, 16'd3, 16'd5};
    step();
    chk("bp_gnt", 32'(gnt), 32'b0001);
    req = 4'b0010;
    step();
    for (int c = 0; c < 5; c++) begin
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_q", 32'(quotient), 32'd10);
      chk("bp_busy", 32'(busy), 32'd1);
      chk("bp_gnt_hold", 32'(gnt), 32'd0);
      step();
    end
    rsp_ready = 1'b1;
    chk("bp_still", 32'(rsp_valid), 32'd1);
    step();
    chk("bp_accept", 32'(rsp_valid), 32'd0);
    chk("bp_idle", 32'(busy), 32'd0);
    chk("bp_nognt", 32'(gnt), 32'd0);
    $display("bp accepted q=10 id=0");
    step();
    chk("bp_next_gnt", 32'(gnt), 32'b0010);
    req = 4'b0000;
    step();
    chk("bp_next_q", 32'(quotient), 32'd3);
    chk("bp_next_id", 32'(rsp_id), 32'd1);
    step();

    // Reset while EXEC is in progress
    run_op(tbl[0]);
    req = 4'b0011;
    dividend = {32'd0, 16'd9, 16'd20};
    divisor  = {32'd0, 16'd3, 16'd4};
    step();
    chk("re_gnt", 32'(gnt), 32'b0010);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("re_valid", 32'(rsp_valid), 32'd0);
    chk("re_gnt0", 32'(gnt), 32'd0);
    chk("re_busy", 32'(busy), 32'd0);
    chk("re_q", 32'(quotient), 32'd0);
    step();
    chk("re_rr0", 32'(gnt), 32'b0001);
    req = 4'b0000;
    step();
    chk("re_rsp_q", 32'(quotient), 32'd5);
    chk("re_rsp_id", 32'(rsp_id), 32'd0);
    $display("reset-in-exec restart id=%0d q=%0d", rsp_id, quotient);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/div_share_arb.md
Name: div_share_arb

Overview:
Round-robin arbiter and sequencer that shares one instance of the team's combinational 16-bit divider module `div` (ports a, b, out, ov) among NREQ requesters. The block does the following:
- Captures the winning requester's operands into registers.
- Gives the divider one full cycle to settle.
- Registers the quotient and flags.
- Returns them on a valid/ready response port tagged with the requester ID.

It sits between the requester blocks and the single shared `div`.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, width of rsp_id; must equal clog2(NREQ)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
req  input  NREQ  per-requester request; held with operands until gnt bit seen
dividend  input  NREQ*16  packed dividends; requester i at [16i+15:16i]
divisor  input  NREQ*16  packed divisors; same packing
gnt  output  NREQ  one-hot, one-cycle accept pulse (registered)
busy  output  1  high whenever FSM is not IDLE
rsp_valid  output  1  result valid
rsp_ready  input  1  consumer accepts result
rsp_id  output  IDW  index of requester that owns the result
quotient  output  16  registered quotient
ov  output  1  registered `div` ov flag (high when quotient is 0, including b==0)
dz  output  1  divisor was zero

Behaviour:
- Clock, reset and FSM:
  - One clock. Reset is synchronous and active-high.
  - FSM states: IDLE, EXEC, RESP.
  - Reset: state=IDLE; rr pointer=0; gnt=0, rsp_valid=0, rsp_id=0, quotient=0, ov=0, dz=0, busy=0.
  - Reset mid-operation (EXEC or RESP) drops the in-flight op. No response is issued and no gnt is left high.
- IDLE, req==0:
  - Stay in IDLE; gnt=0.
- IDLE, req!=0, at the clock edge:
  - Winner = first set bit of req scanning upward from the rr pointer, wrapping mod NREQ.
  - a_q/b_q <= the winner's dividend/divisor.
  - id_q <= winner.
  - gnt <= onehot(winner).
  - rr pointer <= (winner+1) mod NREQ.
  - state <= EXEC.
- EXEC (exactly 1 cycle):
  - gnt is high this cycle only.
  - `div` is driven from a_q/b_q.
  - At the edge: quotient <= div.out, ov <= div.ov, dz <= (b_q==0), rsp_id <= id_q, rsp_valid <= 1, state <= RESP.
- RESP:
  - quotient, ov, dz and rsp_id stay stable while rsp_valid=1 and rsp_ready=0.
  - On an edge with rsp_ready=1: rsp_valid <= 0, state <= IDLE.
  - New requests are not sampled in RESP.
- Timing:
  - Latency: req sampled at edge E0 -> gnt high in cycle E0+1 -> rsp_valid high in cycle E0+2.
  - Minimum occupancy is 3 cycles per operation.
- Requester contract:
  - After seeing its gnt bit, a requester drops req or presents new operands.
  - The earliest next sample is 2 cycles after gnt, so double acceptance cannot occur.
- Arithmetic:
  - Unsigned 16-bit. quotient = floor(a/b) for b != 0.
  - b==0 without the optional feature: quotient=0, ov=1, dz=1.
- Priority: a requester that has just been served drops to lowest priority, so there is no starvation.
- Simultaneous rsp_ready and new req in RESP: the request waits and is sampled in IDLE on the next edge.

Optional Feature:
- Macro: DIV_ZERO_BYPASS_EN.
- When defined:
  - In IDLE, if the winner's divisor is 0, the FSM skips EXEC and goes straight to RESP.
  - It registers quotient=16'hFFFF, ov=1, dz=1, sets rsp_valid=1 and pulses gnt in the same edge.
  - Latency drops to 1 cycle after sampling.
- When undefined: divide-by-zero takes the normal EXEC path, giving quotient=0, ov=1, dz=1.

Test Plan:
- req=0001, dividend0=100, divisor0=7, rsp_ready=1 -> gnt=0001 one cycle later; rsp_valid the next cycle with quotient=14, ov=0, dz=0, rsp_id=0.
- req=0100, 65535/1, then 5/9 -> quotient=65535, ov=0; then quotient=0, ov=1, dz=0, rsp_id=2 both times.
- req=1111 held continuously (operands i*10+10 / 3), rsp_ready=1 -> gnt order 0001, 0010, 0100, 1000, 0001; one result every 3 cycles; quotients 3, 6, 10, 13.
- req=0010, 1000/0 -> dz=1, ov=1, quotient=0 (or 16'hFFFF with DIV_ZERO_BYPASS_EN, rsp_valid 1 cycle after sampling).
- Backpressure: result 50/5 with rsp_ready=0 for 5 cycles -> rsp_valid stays 1, quotient=10 stable, busy=1, no new gnt; accepted on the rsp_ready=1 edge, IDLE the next cycle.
- rst=1 asserted during EXEC -> the next cycle has rsp_valid=0, gnt=0, busy=0, quotient=0; the rr pointer restarts at requester 0.
